// File: rtl/simd_isa_pkg.sv
// SIMD instruction set definitions: opcodes, dot-unit control encoding,
// instruction field layout and the opcode-to-control decode table.
package simd_isa_pkg;

  localparam int unsigned OPCODE_W  = 3;
  localparam int unsigned PE_OP_W   = 2;
  localparam int unsigned FIELD_W   = 10;
  localparam int unsigned R_LSB     = 0;
  localparam int unsigned B_LSB     = FIELD_W;
  localparam int unsigned A_LSB     = 2 * FIELD_W;
  localparam int unsigned OPCODE_LSB = 3 * FIELD_W;

  typedef enum logic [OPCODE_W-1:0] {
    OP_NOP  = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_MUL  = 3'd3,
    OP_DOTS = 3'd4,
    OP_DOTA = 3'd5,
    OP_DOTE = 3'd6,
    OP_HALT = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    DOT_NONE  = 2'b00,
    DOT_START = 2'b01,
    DOT_ACC   = 2'b10,
    DOT_END   = 2'b11
  } dot_ctrl_e;

  typedef struct packed {
    logic [PE_OP_W-1:0] pe_op;
    dot_ctrl_e          dot_ctrl;
    logic               write_en;
    logic               r_select;
  } ctrl_t;

  function automatic ctrl_t decode(input opcode_e op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_ADD:  begin c.pe_op = 2'd0; c.write_en = 1'b1; end
      OP_SUB:  begin c.pe_op = 2'd1; c.write_en = 1'b1; end
      OP_MUL:  begin c.pe_op = 2'd2; c.write_en = 1'b1; end
      OP_DOTS: begin c.pe_op = 2'd2; c.dot_ctrl = DOT_START; end
      OP_DOTA: begin c.pe_op = 2'd2; c.dot_ctrl = DOT_ACC; end
      OP_DOTE: begin
        c.pe_op    = 2'd2;
        c.dot_ctrl = DOT_END;
        c.write_en = 1'b1;
        c.r_select = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ins_ram.sv
// Instruction RAM: one write port, one registered read port, no reset.
module ins_ram #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 64
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/ins_fetch_sequencer.sv
// Instruction fetch/decode sequencer: runs a loaded program from start_pc to HALT,
// presenting each decoded instruction for ISSUE_CYCLES un-stalled cycles.
module ins_fetch_sequencer #(
  parameter int unsigned INS_ADDR_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned OPCODE_WIDTH   = 3,
  parameter int unsigned OP_SEL_WIDTH   = 2,
  parameter int unsigned INS_WIDTH      = 64,
  parameter int unsigned ISSUE_CYCLES   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_en,
  input  logic [INS_ADDR_WIDTH-1:0] load_addr,
  input  logic [INS_WIDTH-1:0]      load_data,
  input  logic                      start,
  input  logic [INS_ADDR_WIDTH-1:0] start_pc,
  input  logic                      stall,
  output logic                      busy,
  output logic                      done,
  output logic                      overrun,
  output logic [INS_ADDR_WIDTH-1:0] pc,
  output logic                      issue_vld,
  output logic [ADDR_WIDTH-1:0]     a_addr,
  output logic [ADDR_WIDTH-1:0]     b_addr,
  output logic [ADDR_WIDTH-1:0]     r_addr,
  output logic [OP_SEL_WIDTH-1:0]   pe_op,
  output logic [1:0]                dot_ctrl,
  output logic                      write_en,
  output logic                      r_select
);
  import simd_isa_pkg::*;

  localparam int unsigned USED_W = OPCODE_WIDTH + 3 * ADDR_WIDTH;
  localparam int unsigned CW     = $clog2(ISSUE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ISSUE_CYCLES - 1);
  localparam logic [INS_ADDR_WIDTH-1:0] PC_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_DONE
  } state_e;

  state_e                    r_state;
  state_e                    w_next;
  logic [INS_ADDR_WIDTH-1:0] r_pc;
  logic                      r_busy;
  logic                      r_overrun;
  logic                      r_issue_vld;
  logic                      r_halt;
  logic [CW-1:0]             r_cnt;
  logic [ADDR_WIDTH-1:0]     r_a;
  logic [ADDR_WIDTH-1:0]     r_b;
  logic [ADDR_WIDTH-1:0]     r_r;
  ctrl_t                     r_ctrl;

  logic [INS_WIDTH-1:0]      w_rdata;
  logic [OPCODE_WIDTH-1:0]   w_op_raw;
  opcode_e                   w_op;
  logic                      w_start;
  logic                      w_issue_end;
  logic                      w_unused_hi;

  ins_ram #(
    .AW (INS_ADDR_WIDTH),
    .DW (INS_WIDTH)
  ) u_ram (
    .i_clk   (clk),
    .i_we    (load_en && !r_busy),
    .i_waddr (load_addr),
    .i_wdata (load_data),
    .i_raddr (r_pc),
    .o_rdata (w_rdata)
  );

  assign w_op_raw    = w_rdata[3*ADDR_WIDTH +: OPCODE_WIDTH];
  assign w_op        = opcode_e'(w_op_raw);
  assign w_unused_hi = ^w_rdata[INS_WIDTH-1:USED_W];

  assign w_start     = ((r_state == S_IDLE) || (r_state == S_DONE)) && start && !load_en;
  assign w_issue_end = (r_state == S_ISSUE) && !stall && (r_cnt == CNT_LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: w_next = w_start ? S_FETCH : S_IDLE;
      S_FETCH:        w_next = S_DECODE;
      S_DECODE:       w_next = S_ISSUE;
      S_ISSUE: begin
        if (w_issue_end) w_next = (r_halt || (r_pc == PC_MAX)) ? S_DONE : S_FETCH;
      end
      default:        w_next = S_IDLE;
    endcase
  end

  // HALT still occupies its issue slot, but with issue_vld held low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pc        <= '0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
      r_issue_vld <= 1'b0;
      r_halt      <= 1'b0;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_r         <= '0;
      r_ctrl      <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_pc      <= start_pc;
        r_overrun <= 1'b0;
        r_busy    <= 1'b1;
      end
      if (r_state == S_DECODE) begin
        r_r         <= w_rdata[0 +: ADDR_WIDTH];
        r_b         <= w_rdata[ADDR_WIDTH +: ADDR_WIDTH];
        r_a         <= w_rdata[2*ADDR_WIDTH +: ADDR_WIDTH];
        r_ctrl      <= decode(w_op);
        r_halt      <= (w_op == OP_HALT);
        r_issue_vld <= (w_op != OP_HALT);
        r_cnt       <= '0;
      end
      if ((r_state == S_ISSUE) && !stall && !w_issue_end) r_cnt <= r_cnt + CW'(1);
      if (w_issue_end) begin
        r_issue_vld <= 1'b0;
        if (r_halt) begin
          r_busy <= 1'b0;
        end else if (r_pc == PC_MAX) begin
          r_busy    <= 1'b0;
          r_overrun <= 1'b1;
        end else begin
          r_pc <= r_pc + 1'b1;
        end
      end
    end
  end

  assign busy      = r_busy;
  assign done      = (r_state == S_DONE);
  assign overrun   = r_overrun;
  assign pc        = r_pc;
  assign issue_vld = r_issue_vld;
  assign a_addr    = r_a;
  assign b_addr    = r_b;
  assign r_addr    = r_r;
  assign pe_op     = OP_SEL_WIDTH'(r_ctrl.pe_op);
  assign dot_ctrl  = r_ctrl.dot_ctrl;
  assign write_en  = w_issue_end && r_ctrl.write_en;
  assign r_select  = r_ctrl.r_select;

endmodule

// File: tb/tb_ins_fetch_sequencer.sv
// Directed bench for ins_fetch_sequencer: checks at negedge+1 against hand-derived cycle timings.
module tb_ins_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [63:0] load_data;
  logic        start;
  logic [7:0]  start_pc;
  logic        stall;
  logic        busy, done, overrun, issue_vld, write_en, r_select;
  logic [7:0]  pc;
  logic [9:0]  a_addr, b_addr, r_addr;
  logic [1:0]  pe_op, dot_ctrl;

  int checks   = 0;
  int failures = 0;

  ins_fetch_sequencer #(
    .INS_ADDR_WIDTH (8),
    .ADDR_WIDTH     (10),
    .OPCODE_WIDTH   (3),
    .OP_SEL_WIDTH   (2),
    .INS_WIDTH      (64),
    .ISSUE_CYCLES   (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .start     (start),
    .start_pc  (start_pc),
    .stall     (stall),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun),
    .pc        (pc),
    .issue_vld (issue_vld),
    .a_addr    (a_addr),
    .b_addr    (b_addr),
    .r_addr    (r_addr),
    .pe_op     (pe_op),
    .dot_ctrl  (dot_ctrl),
    .write_en  (write_en),
    .r_select  (r_select)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ins(input logic [2:0] op, input logic [9:0] a,
                                      input logic [9:0] b, input logic [9:0] r);
    return {31'd0, op, a, b, r};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nc();
    @(negedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] addr, input logic [63:0] data);
    load_en   = 1'b1;
    load_addr = addr;
    load_data = data;
    nc();
    load_en   = 1'b0;
  endtask

  // Leaves the bench one cycle after the start was sampled (FETCH cycle).
  task automatic go(input logic [7:0] spc);
    start    = 1'b1;
    start_pc = spc;
    nc();
    start    = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int n = 0;
    while (!done && n < max) begin
      nc();
      n++;
    end
    chk(tag, done, 1'b1);
  endtask

  logic [1:0] exp_dot [4];
  logic       exp_we  [4];

  initial begin
    rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; start_pc = '0; stall = 1'b0;
    nc();
    chk("rst_busy", busy, 0);
    chk("rst_vld", issue_vld, 0);
    chk("rst_pc", pc, 0);
    chk("rst_addr", {a_addr, b_addr, r_addr}, 0);
    chk("rst_ctl", {pe_op, dot_ctrl, write_en, r_select, done, overrun}, 0);
    nc();
    rst = 1'b0;
    nc();

    // 1: ADD then HALT
    load(8'd0, ins(3'd1, 10'd1, 10'd2, 10'd3));
    load(8'd1, ins(3'd7, 10'd0, 10'd0, 10'd0));
    go(8'd0);
    chk("t1_busy", busy, 1);
    chk("t1_vld_c1", issue_vld, 0);
    nc();
    chk("t1_vld_c2", issue_vld, 0);
    nc();
    chk("t1_vld_c3", issue_vld, 1);
    chk("t1_pe_op", pe_op, 0);
    chk("t1_abr", {a_addr, b_addr, r_addr}, {10'd1, 10'd2, 10'd3});
    chk("t1_we_c3", write_en, 0);
    nc();
    chk("t1_vld_c4", issue_vld, 1);
    chk("t1_we_c4", write_en, 1);
    nc();
    chk("t1_vld_c5", issue_vld, 0);
    chk("t1_pc_c5", pc, 1);
    nc(); nc();
    chk("t1_halt_vld", issue_vld, 0);
    chk("t1_halt_busy", busy, 1);
    nc();
    chk("t1_halt_we", write_en, 0);
    nc();
    chk("t1_done", done, 1);
    chk("t1_busy_fall", busy, 0);
    nc();
    chk("t1_done_pulse", done, 0);

    // 2: dot-product sequence
    load(8'd10, ins(3'd4, 10'd10, 10'd20, 10'd30));
    load(8'd11, ins(3'd5, 10'd11, 10'd21, 10'd31));
    load(8'd12, ins(3'd5, 10'd12, 10'd22, 10'd32));
    load(8'd13, ins(3'd6, 10'd13, 10'd23, 10'd33));
    load(8'd14, ins(3'd7, 10'd0, 10'd0, 10'd0));
    exp_dot = '{2'b01, 2'b10, 2'b10, 2'b11};
    exp_we  = '{1'b0, 1'b0, 1'b0, 1'b1};
    go(8'd10);
    nc(); nc();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t2_vld_%0d", k), issue_vld, 1);
      chk($sformatf("t2_dot_%0d", k), dot_ctrl, exp_dot[k]);
      chk($sformatf("t2_pe_%0d", k), pe_op, 2);
      chk($sformatf("t2_rsel_%0d", k), r_select, exp_we[k]);
      chk($sformatf("t2_a_%0d", k), a_addr, 10 + k);
      chk($sformatf("t2_we0_%0d", k), write_en, 0);
      nc();
      chk($sformatf("t2_we1_%0d", k), write_en, exp_we[k]);
      nc(); nc(); nc();
    end
    chk("t2_halt_vld", issue_vld, 0);
    nc(); nc();
    chk("t2_done", done, 1);
    nc();

    // 3: stall mid-issue of SUB
    load(8'd20, ins(3'd2, 10'd21, 10'd22, 10'd23));
    load(8'd21, ins(3'd7, 10'd0, 10'd0, 10'd0));
    go(8'd20);
    nc(); nc();
    chk("t3_vld", issue_vld, 1);
    chk("t3_pe_op", pe_op, 1);
    chk("t3_we_first", write_en, 0);
    nc();
    stall = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t3_stall_we_%0d", k), write_en, 0);
      chk($sformatf("t3_stall_hold_%0d", k), {issue_vld, pe_op, a_addr, b_addr, r_addr},
          {1'b1, 2'd1, 10'd21, 10'd22, 10'd23});
      nc();
    end
    stall = 1'b0;
    #1;
    chk("t3_release_we", write_en, 1);
    chk("t3_release_vld", issue_vld, 1);
    nc();
    chk("t3_after_vld", issue_vld, 0);
    chk("t3_after_we", write_en, 0);
    nc(); nc(); nc(); nc();
    chk("t3_done", done, 1);
    nc();

    // 4: PC wrap without HALT
    load(8'd254, ins(3'd1, 10'd4, 10'd5, 10'd6));
    load(8'd255, ins(3'd3, 10'd7, 10'd8, 10'd9));
    go(8'd254);
    nc(); nc();
    chk("t4_vld0", issue_vld, 1);
    chk("t4_pc0", pc, 254);
    chk("t4_pe0", pe_op, 0);
    nc(); nc(); nc(); nc();
    chk("t4_vld1", issue_vld, 1);
    chk("t4_pc1", pc, 255);
    chk("t4_pe1", pe_op, 2);
    chk("t4_a1", a_addr, 7);
    nc();
    chk("t4_we1", write_en, 1);
    nc();
    chk("t4_done", done, 1);
    chk("t4_overrun", overrun, 1);
    chk("t4_busy", busy, 0);
    nc();
    chk("t4_overrun_sticky", overrun, 1);
    chk("t4_done_pulse", done, 0);
    go(8'd0);
    chk("t4_overrun_clr", overrun, 0);
    wait_done("t4_rerun_done", 20);
    nc();

    // 5: load priority over start, load ignored while busy
    load_en = 1'b1; load_addr = 8'd30; load_data = ins(3'd1, 10'd11, 10'd12, 10'd13);
    start = 1'b1; start_pc = 8'd30;
    nc();
    load_en = 1'b0; start = 1'b0;
    chk("t5_busy_idle", busy, 0);
    nc();
    chk("t5_busy_idle2", busy, 0);
    load(8'd31, ins(3'd7, 10'd0, 10'd0, 10'd0));
    go(8'd30);
    load_en = 1'b1; load_addr = 8'd31; load_data = ins(3'd1, 10'd1, 10'd1, 10'd1);
    nc();
    load_en = 1'b0;
    nc();
    chk("t5_vld", issue_vld, 1);
    chk("t5_a_loaded", a_addr, 11);
    nc(); nc(); nc(); nc();
    chk("t5_busy_load_ignored", issue_vld, 0);
    nc(); nc();
    chk("t5_done", done, 1);
    nc();

    // 6: asynchronous reset during ISSUE, then identical rerun
    go(8'd0);
    nc(); nc();
    chk("t6_vld_pre", issue_vld, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_vld", issue_vld, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_pc", pc, 0);
    chk("t6_rst_abr", {a_addr, b_addr, r_addr}, 0);
    chk("t6_rst_ctl", {pe_op, dot_ctrl, write_en, r_select}, 0);
    nc();
    rst = 1'b0;
    nc();
    go(8'd0);
    nc(); nc();
    chk("t6_re_vld", issue_vld, 1);
    chk("t6_re_abr", {a_addr, b_addr, r_addr}, {10'd1, 10'd2, 10'd3});
    nc();
    chk("t6_re_we", write_en, 1);
    nc(); nc(); nc(); nc(); nc();
    chk("t6_re_done", done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
